// File: rtl/fsmc_reg_slave.sv
// FSMC asynchronous-bus register slave: synchronises the bus strobes, decodes
// one read or write per transaction and drives a small register file.
// Optional macro FSMC_RD_INC_EN: a read increments the addressed register.
module fsmc_reg_slave #(
    parameter int unsigned ADRW = 2,
    parameter int unsigned DATW = 8,
    parameter int unsigned NREG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aNE,
    input  logic                 aNOE,
    input  logic                 aNWE,
    input  logic [ADRW-1:0]      aAn,
    input  logic [DATW-1:0]      aDn_in,
    output logic                 io_output,
    output logic [DATW-1:0]      io_data,
    output logic                 wr_strobe,
    output logic                 rd_strobe,
    output logic [ADRW-1:0]      w_adr,
    output logic [ADRW-1:0]      r_adr,
    output logic [DATW-1:0]      w_data,
    output logic [NREG*DATW-1:0] regs_flat
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        WRITE = 4'b0010,
        READ1 = 4'b0100,
        READ2 = 4'b1000
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      ne_sync;
    logic [1:0]      noe_sync;
    logic [1:0]      nwe_sync;
    logic [1:0]      settle;
    logic            sne;
    logic            snoe;
    logic            snwe;
    logic            armed;
    logic            go_wr;
    logic            go_rd;
    logic            arm_set;
    logic [DATW-1:0] rd_mux;
    logic [DATW-1:0] rd_buf;
    logic [DATW-1:0] regs [NREG];

    // Two-flop synchronisers; settle marks when the flops hold real pad samples
    // again after reset, so their reset value cannot arm the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            ne_sync  <= 2'b11;
            noe_sync <= 2'b11;
            nwe_sync <= 2'b11;
            settle   <= 2'b00;
        end else begin
            ne_sync  <= {ne_sync[0], aNE};
            noe_sync <= {noe_sync[0], aNOE};
            nwe_sync <= {nwe_sync[0], aNWE};
            settle   <= {settle[0], 1'b1};
        end
    end

    assign sne  = ne_sync[1];
    assign snoe = noe_sync[1];
    assign snwe = nwe_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; armed is consumed by each accepted transaction.
    always_comb begin
        state_d = state_q;
        go_wr   = 1'b0;
        go_rd   = 1'b0;
        arm_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (settle[1] && (sne || (snoe && snwe))) begin
                    arm_set = 1'b1;
                end
                if (armed && !sne && !snwe) begin
                    go_wr   = 1'b1;
                    state_d = WRITE;
                end else if (armed && !sne && !snoe && snwe) begin
                    go_rd   = 1'b1;
                    state_d = READ1;
                end
            end
            WRITE: begin
                if (sne || snwe) begin
                    state_d = IDLE;
                end
            end
            READ1: begin
                state_d = (!sne && !snoe) ? READ2 : IDLE;
            end
            READ2: begin
                if (sne || snoe) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            w_adr     <= '0;
            r_adr     <= '0;
            w_data    <= '0;
            rd_buf    <= '0;
        end else begin
            wr_strobe <= go_wr;
            rd_strobe <= go_rd;
            if (go_wr || go_rd) begin
                armed <= 1'b0;
            end else if (arm_set) begin
                armed <= 1'b1;
            end
            if (go_wr) begin
                w_adr  <= aAn;
                w_data <= aDn_in;
            end
            if (go_rd) begin
                r_adr <= aAn;
            end
            if (state_q == READ1) begin
                rd_buf <= rd_mux;
            end
        end
    end

    // Unimplemented addresses read as zero.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (r_adr == ADRW'(i)) begin
                rd_mux = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_strobe && (w_adr == ADRW'(i))) begin
                    regs[i] <= w_data;
                end
`ifdef FSMC_RD_INC_EN
                else if (rd_strobe && (r_adr == ADRW'(i))) begin
                    regs[i] <= regs[i] + DATW'(1);
                end
`endif
            end
        end
    end

    for (genvar g = 0; g < int'(NREG); g++) begin : g_flat
        assign regs_flat[g*DATW +: DATW] = regs[g];
    end

    assign io_output = (state_q == READ2) && !sne && !snoe;
    assign io_data   = rd_buf;

endmodule

// File: tb/tb_fsmc_reg_slave.sv
// Directed bench for fsmc_reg_slave: writes, reads, out-of-range access,
// reset during transactions, simultaneous strobes and the read-increment option.
module tb_fsmc_reg_slave;

    localparam int unsigned ADRW = 2;
    localparam int unsigned DATW = 8;
    localparam int unsigned NREG = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 aNE = 1'b1;
    logic                 aNOE = 1'b1;
    logic                 aNWE = 1'b1;
    logic [ADRW-1:0]      aAn = '0;
    logic [DATW-1:0]      aDn_in = '0;
    logic                 io_output;
    logic [DATW-1:0]      io_data;
    logic                 wr_strobe;
    logic                 rd_strobe;
    logic [ADRW-1:0]      w_adr;
    logic [ADRW-1:0]      r_adr;
    logic [DATW-1:0]      w_data;
    logic [NREG*DATW-1:0] regs_flat;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;
    int oe_cnt = 0;
    logic [DATW-1:0] oe_data = '0;

    fsmc_reg_slave #(.ADRW(ADRW), .DATW(DATW), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .aNE       (aNE),
        .aNOE      (aNOE),
        .aNWE      (aNWE),
        .aAn       (aAn),
        .aDn_in    (aDn_in),
        .io_output (io_output),
        .io_data   (io_data),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .w_adr     (w_adr),
        .r_adr     (r_adr),
        .w_data    (w_data),
        .regs_flat (regs_flat)
    );

    always #5 clk = ~clk;

    // Strobe and pad-drive monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) wr_cnt++;
            if (rd_strobe) rd_cnt++;
            if (wr_strobe && rd_strobe) both_cnt++;
        end
        if (io_output) begin
            oe_cnt++;
            oe_data = io_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_idle();
        aNE  = 1'b1;
        aNOE = 1'b1;
        aNWE = 1'b1;
    endtask

    task automatic write_bus(input logic [ADRW-1:0] adr, input logic [DATW-1:0] dat, input int n);
        aAn    = adr;
        aDn_in = dat;
        aNE    = 1'b0;
        aNWE   = 1'b0;
        cyc(n);
        bus_idle();
        cyc(6);
    endtask

    task automatic read_bus(input logic [ADRW-1:0] adr, input int n,
                            output logic [DATW-1:0] d, output int oen);
        int o0;
        o0   = oe_cnt;
        aAn  = adr;
        aNE  = 1'b0;
        aNOE = 1'b0;
        cyc(n);
        d   = oe_data;
        oen = oe_cnt - o0;
        bus_idle();
        cyc(6);
    endtask

    initial begin
        int w0;
        int r0;
        int o0;
        int oen;
        logic [DATW-1:0] d;
        logic [DATW-1:0] d2;
        logic [23:0] exp_regs;

        cyc(3);
        check_eq("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check_eq("rst_rd_strobe", 32'(rd_strobe), 32'd0);
        check_eq("rst_io_output", 32'(io_output), 32'd0);
        check_eq("rst_io_data",   32'(io_data),   32'd0);
        check_eq("rst_w_adr",     32'(w_adr),     32'd0);
        check_eq("rst_r_adr",     32'(r_adr),     32'd0);
        check_eq("rst_w_data",    32'(w_data),    32'd0);
        check_eq("rst_regs",      32'(regs_flat), 32'd0);
        rst = 1'b0;
        cyc(6);

        // Basic write
        w0 = wr_cnt; r0 = rd_cnt;
        write_bus(2'd1, 8'hA5, 6);
        check_eq("wr_count",  32'(wr_cnt - w0), 32'd1);
        check_eq("wr_no_rd",  32'(rd_cnt - r0), 32'd0);
        check_eq("wr_w_adr",  32'(w_adr), 32'd1);
        check_eq("wr_w_data", 32'(w_data), 32'hA5);
        check_eq("wr_regs",   32'(regs_flat), 32'h00A500);

        // Basic read
        w0 = wr_cnt; r0 = rd_cnt;
        read_bus(2'd1, 8, d, oen);
`ifdef FSMC_RD_INC_EN
        exp_regs = 24'h00A600;
`else
        exp_regs = 24'h00A500;
`endif
        check_eq("rd_count",    32'(rd_cnt - r0), 32'd1);
        check_eq("rd_no_wr",    32'(wr_cnt - w0), 32'd0);
        check_eq("rd_oe_seen",  32'(oen > 0), 32'd1);
        check_eq("rd_pad_data", 32'(d), 32'hA5);
        check_eq("rd_io_data",  32'(io_data), 32'hA5);
        check_eq("rd_oe_off",   32'(io_output), 32'd0);
        check_eq("rd_r_adr",    32'(r_adr), 32'd1);
        check_eq("rd_regs",     32'(regs_flat), 32'(exp_regs));

        // Out-of-range write then read
        w0 = wr_cnt; r0 = rd_cnt;
        write_bus(2'd3, 8'h3C, 6);
        check_eq("oor_wr_count", 32'(wr_cnt - w0), 32'd1);
        check_eq("oor_w_adr",    32'(w_adr), 32'd3);
        check_eq("oor_wr_regs",  32'(regs_flat), 32'(exp_regs));
        read_bus(2'd3, 8, d, oen);
        check_eq("oor_rd_count", 32'(rd_cnt - r0), 32'd1);
        check_eq("oor_oe_seen",  32'(oen > 0), 32'd1);
        check_eq("oor_pad_data", 32'(d), 32'h00);
        check_eq("oor_io_data",  32'(io_data), 32'h00);
        check_eq("oor_rd_regs",  32'(regs_flat), 32'(exp_regs));

        // Reset while a write is held on the bus
        aAn = 2'd0; aDn_in = 8'h77; aNE = 1'b0; aNWE = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        w0 = wr_cnt;
        cyc(10);
        check_eq("rstw_no_strobe", 32'(wr_cnt - w0), 32'd0);
        check_eq("rstw_regs",      32'(regs_flat), 32'd0);
        bus_idle();
        cyc(6);
        write_bus(2'd2, 8'h11, 6);
        check_eq("rstw_new_count", 32'(wr_cnt - w0), 32'd1);
        check_eq("rstw_new_regs",  32'(regs_flat), 32'h110000);

        // Reset while the pad is driven
        aAn = 2'd2; aNE = 1'b0; aNOE = 1'b0;
        cyc(6);
        check_eq("rstr_oe_before", 32'(io_output), 32'd1);
        check_eq("rstr_io_data",   32'(io_data), 32'h11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rstr_oe_after", 32'(io_output), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_idle();
        cyc(8);
        check_eq("rstr_regs", 32'(regs_flat), 32'd0);

        // NOE and NWE asserted together: write wins
        w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
        aAn = 2'd1; aDn_in = 8'h5A; aNE = 1'b0; aNOE = 1'b0; aNWE = 1'b0;
        cyc(6);
        bus_idle();
        cyc(6);
        check_eq("sim_wr_count", 32'(wr_cnt - w0), 32'd1);
        check_eq("sim_rd_count", 32'(rd_cnt - r0), 32'd0);
        check_eq("sim_oe_count", 32'(oe_cnt - o0), 32'd0);
        check_eq("sim_regs",     32'(regs_flat), 32'h005A00);

        // Back-to-back reads of a saturated register
        write_bus(2'd0, 8'hFF, 6);
        read_bus(2'd0, 8, d, oen);
        read_bus(2'd0, 8, d2, oen);
        check_eq("inc_first", 32'(d), 32'hFF);
`ifdef FSMC_RD_INC_EN
        check_eq("inc_second", 32'(d2), 32'h00);
        check_eq("inc_reg0",   32'(regs_flat[7:0]), 32'h01);
`else
        check_eq("inc_second", 32'(d2), 32'hFF);
        check_eq("inc_reg0",   32'(regs_flat[7:0]), 32'hFF);
`endif

        check_eq("one_strobe_per_cycle", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
